iter_mul_parity: RTL and testbench
==================================

// Module: iter_mul_parity
// PURPOSE
//  Iterative (multi-cycle) multiplier. Multiplies two WIDTH-bit operands and returns the
//  2*WIDTH-bit product plus its XOR-reduction parity bit.
//  Generalises the fixed-width combinational product/parity cone:
//  - operand width and bits-per-cycle are parameters;
//  - a run-time mode selects integer or carry-less (GF(2)) multiply;
//  - valid/ready handshakes sit on both sides.
//  Sits between an operand producer and a result/checksum consumer in the datapath.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH
//  STEP   1  multiplier bits consumed per cycle; WIDTH % STEP == 0 (elaboration error otherwise)
//  N (localparam) = WIDTH/STEP, number of iteration cycles
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands/mode valid
//  in_ready   out  1        block can accept operands
//  in_a       in   WIDTH    multiplicand (unsigned)
//  in_b       in   WIDTH    multiplier (unsigned)
//  in_clmul   in   1        0 = integer multiply, 1 = carry-less multiply
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_prod   out  2*WIDTH  product
//  out_par    out  1        ^out_prod (1 = odd number of ones)
// BEHAVIOUR
//  Reset
//   - FSM goes to IDLE. All registers clear.
//   - in_ready=1 (from the cycle after rst deasserts), out_valid=0, out_prod=0, out_par=0.
//   - rst asserted in any state (mid-BUSY, DONE) aborts the operation; the result is discarded.
//  FSM IDLE -> BUSY -> DONE -> IDLE
//   IDLE
//    - in_ready=1.
//    - On in_valid&&in_ready: latch a, b, mode; acc=0; cnt=0; go to BUSY.
//   BUSY
//    - in_ready=0, out_valid=0.
//    - Each cycle, take the low STEP bits of b: acc += (a<<offset)*bits.
//      Integer: add with carry. Carry-less: XOR combine, no carry.
//    - b >>= STEP; cnt++.
//    - After the N-th step, go to DONE.
//   DONE
//    - out_valid=1. out_prod=acc and out_par are registered.
//    - Outputs hold stable while out_ready=0.
//    - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
//    - in_ready=0 in DONE; no overlap between operations.
//  Timing
//   - Accept edge in cycle 0 -> out_valid=1 in cycle N. Latency is independent of operand values.
//   - Peak throughput is one op per N+2 cycles.
//  Arithmetic
//   - acc is 2*WIDTH bits.
//   - Integer product never overflows 2*WIDTH. Carry-less product occupies 2*WIDTH-1 bits; the MSB is 0.
//   - out_par is computed from the final acc in the transition to DONE (registered), not from a
//     running XOR of partial products.
//  Boundaries
//   - A zero operand still takes N cycles.
//   - in_valid while in_ready=0 is ignored; the producer must hold it.
//   - Changing in_clmul after accept has no effect.
// STRUCTURE
//  Shared package mul_pkg:
//   - typedef enum {IDLE, BUSY, DONE} mul_state_t;
//   - localparams MODE_INT=1'b0, MODE_CLMUL=1'b1.
//  Sub-module mul_step (combinational), WIDTH/STEP-parameterised:
//   - inputs: acc, a, b_slice, offset, mode.
//   - output: next acc.
//  Top level holds the FSM, counter and operand/result registers.
// TESTING
//  1 WIDTH=8,STEP=1, int: a=0x07, b=0x03 accepted cycle 0 -> out_valid cycle 8, out_prod=0x0015, out_par=1
//  2 Same operands, clmul=1 -> out_prod=0x0009, out_par=0
//  3 int 0xFF*0xFF -> out_prod=0xFE01, out_par=0; 0x00*0xAB -> 0x0000, par=0, still 8 cycles
//  4 out_ready low 5 cycles in DONE -> out_valid, out_prod, out_par stable, in_ready=0; handshake -> IDLE next cycle
//  5 rst pulsed in 3rd BUSY cycle -> next cycle in_ready=1, out_valid=0, out_prod=0; no result emitted
//  6 WIDTH=8,STEP=4: 200*255 -> out_valid cycle 2, out_prod=0xC738, out_par=0; random int/clmul vs model

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier slice.
package mul_pkg;

  // Operation sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Run-time multiply mode encoding.
  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_CLMUL = 1'b1;

endpackage

// File: rtl/mul_step.sv
// One iteration of the shift-and-combine multiplier: folds STEP multiplier
// bits, placed at bit position 'offset', into the running accumulator.
// Integer mode adds the partial products, carry-less mode XORs them.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int OFFW  = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [STEP-1:0]    b_slice,
  input  logic [OFFW-1:0]    offset,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] sum_s;
  logic [2*WIDTH-1:0] xor_s;
  logic [2*WIDTH-1:0] part_s;
  logic [OFFW-1:0]    shamt_s;

  // Combine each selected shifted copy of a into both candidate results.
  always_comb begin
    sum_s   = acc;
    xor_s   = acc;
    part_s  = '0;
    shamt_s = '0;
    for (int j = 0; j < STEP; j++) begin
      shamt_s = offset + OFFW'(j);
      part_s  = {{WIDTH{1'b0}}, a} << shamt_s;
      if (b_slice[j]) begin
        sum_s = sum_s + part_s;
        xor_s = xor_s ^ part_s;
      end else begin
        sum_s = sum_s;
        xor_s = xor_s;
      end
    end
    if (mode == MODE_CLMUL) begin
      acc_nxt = xor_s;
    end else begin
      acc_nxt = sum_s;
    end
  end

endmodule

// File: rtl/iter_mul_parity.sv
// Iterative integer / carry-less multiplier with a registered parity bit.
// Operands are accepted in IDLE, the product is built over N = WIDTH/STEP
// BUSY cycles, and the result is held in DONE until the consumer takes it.
module iter_mul_parity
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_clmul,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_par
);

  localparam int N    = WIDTH / STEP;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int OFFW = (WIDTH > 1) ? $clog2(2 * WIDTH) : 1;

  // A step size that does not divide the operand width has no meaning here.
  generate
    if ((WIDTH % STEP) != 0) begin : g_bad_step
      $error("iter_mul_parity: WIDTH must be a multiple of STEP");
    end
  endgenerate

  // Even-parity helper: 1 when the vector holds an odd number of ones.
  function automatic logic calc_par(input logic [2*WIDTH-1:0] v);
    return ^v;
  endfunction

  mul_state_t         state_r;
  mul_state_t         state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               mode_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] out_prod_r;
  logic               out_par_r;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [OFFW-1:0]    offset_s;
  logic               last_step_s;

  assign offset_s    = OFFW'(cnt_r) * OFFW'(STEP);
  assign last_step_s = (cnt_r == CW'(N - 1));

  mul_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .OFFW  (OFFW)
  ) u_step (
    .acc     (acc_r),
    .a       (a_r),
    .b_slice (b_r[STEP-1:0]),
    .offset  (offset_s),
    .mode    (mode_r),
    .acc_nxt (acc_nxt_s)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: accept, iterate N times, hold until consumed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_step_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result/parity registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      mode_r     <= MODE_INT;
      acc_r      <= '0;
      cnt_r      <= '0;
      out_prod_r <= '0;
      out_par_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r    <= in_a;
            b_r    <= in_b;
            mode_r <= in_clmul;
            acc_r  <= '0;
            cnt_r  <= '0;
          end
        end
        BUSY: begin
          acc_r <= acc_nxt_s;
          b_r   <= b_r >> STEP;
          cnt_r <= cnt_r + CW'(1);
          // Parity is taken from the finished product, not accumulated.
          if (last_step_s) begin
            out_prod_r <= acc_nxt_s;
            out_par_r  <= calc_par(acc_nxt_s);
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_prod  = out_prod_r;
  assign out_par   = out_par_r;

endmodule

// File: tb/tb_iter_mul_parity.sv
// Directed self-checking bench for iter_mul_parity: one instance with
// STEP=1 (8 iterations) and one with STEP=4 (2 iterations).
module tb_iter_mul_parity;

  logic        clk;
  logic        rst;

  logic        in_valid8, in_ready8, in_clmul8, out_valid8, out_ready8, out_par8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_prod8;

  logic        in_valid4, in_ready4, in_clmul4, out_valid4, out_ready4, out_par4;
  logic [7:0]  in_a4, in_b4;
  logic [15:0] out_prod4;

  int n_vec;
  int n_err;

  iter_mul_parity #(.WIDTH(8), .STEP(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_clmul(in_clmul8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_prod(out_prod8), .out_par(out_par8)
  );

  iter_mul_parity #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_clmul(in_clmul4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_prod(out_prod4), .out_par(out_par4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: plain integer multiply or XOR of shifted copies.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic m);
    logic [15:0] r;
    r = 16'h0000;
    if (!m) begin
      r = {8'h00, a} * {8'h00, b};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (b[i]) r = r ^ ({8'h00, a} << i);
      end
    end
    return r;
  endfunction

  // Launch one operation on the STEP=1 instance; returns latency and result.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                         output int lat, output logic [15:0] p, output logic par);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_a8 = a; in_b8 = b; in_clmul8 = m; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; in_clmul8 = ~m; in_a8 = ~a; in_b8 = 8'h5A;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid8) begin
        lat = c;
        break;
      end
    end
    p = out_prod8;
    par = out_par8;
  endtask

  // Same for the STEP=4 instance.
  task automatic run_op4(input logic [7:0] a, input logic [7:0] b, input logic m,
                         output int lat, output logic [15:0] p, output logic par);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_a4 = a; in_b4 = b; in_clmul4 = m; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0; in_clmul4 = ~m; in_a4 = ~a; in_b4 = 8'hA5;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid4) begin
        lat = c;
        break;
      end
    end
    p = out_prod4;
    par = out_par4;
  endtask

  task automatic hs8();
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  task automatic hs4();
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid8: got %b want 0", out_valid8); end
    n_vec++; if (out_prod8 !== 16'h0000) begin n_err++; $display("FAIL rst_out_prod8: got %h want 0000", out_prod8); end
    n_vec++; if (out_par8 !== 1'b0) begin n_err++; $display("FAIL rst_out_par8: got %b want 0", out_par8); end
    n_vec++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid4: got %b want 0", out_valid4); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready8: got %b want 1", in_ready8); end
    n_vec++; if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready4: got %b want 1", in_ready4); end
  endtask

  task automatic test_int();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vp [4];
    logic        vq [4];
    int lat; logic [15:0] p; logic par;
    va = '{8'h07, 8'hFF, 8'h00, 8'h80};
    vb = '{8'h03, 8'hFF, 8'hAB, 8'h80};
    vp = '{16'h0015, 16'hFE01, 16'h0000, 16'h4000};
    vq = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b0, lat, p, par);
      n_vec++; if (lat !== 8) begin n_err++; $display("FAIL int_lat[%0d]: got %0d want 8", i, lat); end
      n_vec++; if (p !== vp[i]) begin n_err++; $display("FAIL int_prod[%0d]: got %h want %h", i, p, vp[i]); end
      n_vec++; if (par !== vq[i]) begin n_err++; $display("FAIL int_par[%0d]: got %b want %b", i, par, vq[i]); end
      hs8();
    end
  endtask

  task automatic test_clmul();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vp [4];
    logic        vq [4];
    int lat; logic [15:0] p; logic par;
    va = '{8'h07, 8'hFF, 8'h80, 8'h53};
    vb = '{8'h03, 8'hFF, 8'h80, 8'hCA};
    vp = '{16'h0009, 16'h5555, 16'h4000, 16'h3F7E};
    vq = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b1, lat, p, par);
      n_vec++; if (lat !== 8) begin n_err++; $display("FAIL clmul_lat[%0d]: got %0d want 8", i, lat); end
      n_vec++; if (p !== vp[i]) begin n_err++; $display("FAIL clmul_prod[%0d]: got %h want %h", i, p, vp[i]); end
      n_vec++; if (par !== vq[i]) begin n_err++; $display("FAIL clmul_par[%0d]: got %b want %b", i, par, vq[i]); end
      hs8();
    end
  endtask

  task automatic test_hold();
    int lat; logic [15:0] p; logic par;
    run_op8(8'h0D, 8'h0B, 1'b0, lat, p, par);
    n_vec++; if (p !== 16'h008F) begin n_err++; $display("FAIL hold_prod0: got %h want 008F", p); end
    in_a8 = 8'h11; in_b8 = 8'h22; in_clmul8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid8); end
      n_vec++; if (out_prod8 !== 16'h008F) begin n_err++; $display("FAIL hold_prod[%0d]: got %h want 008F", i, out_prod8); end
      n_vec++; if (out_par8 !== 1'b1) begin n_err++; $display("FAIL hold_par[%0d]: got %b want 1", i, out_par8); end
      n_vec++; if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready8); end
    end
    in_valid8 = 1'b0;
    hs8();
    @(negedge clk);
    n_vec++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL hold_after_hs_valid: got %b want 0", out_valid8); end
    n_vec++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL hold_after_hs_ready: got %b want 1", in_ready8); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    in_a8 = 8'h07; in_b8 = 8'h03; in_clmul8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b want 1", in_ready8); end
    n_vec++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b want 0", out_valid8); end
    n_vec++; if (out_prod8 !== 16'h0000) begin n_err++; $display("FAIL abort_out_prod: got %h want 0000", out_prod8); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid8 !== 1'b0) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    logic [15:0] p1, p2;
    int extra;
    k1 = -1; k2 = -1; extra = 0; p1 = 16'h0000; p2 = 16'h0000;
    @(negedge clk);
    out_ready8 = 1'b1;
    in_a8 = 8'h05; in_b8 = 8'h06; in_clmul8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_a8 = 8'h09; in_b8 = 8'h09;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid8) begin
        if (k1 < 0) begin
          k1 = c; p1 = out_prod8;
        end else if (k2 < 0) begin
          k2 = c; p2 = out_prod8; in_valid8 = 1'b0;
        end else begin
          extra++;
        end
      end
    end
    out_ready8 = 1'b0;
    in_valid8 = 1'b0;
    n_vec++; if (k1 !== 8) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want 8", k1); end
    n_vec++; if (p1 !== 16'h001E) begin n_err++; $display("FAIL b2b_first_prod: got %h want 001E", p1); end
    n_vec++; if (k2 !== 18) begin n_err++; $display("FAIL b2b_second_cycle: got %0d want 18", k2); end
    n_vec++; if (p2 !== 16'h0051) begin n_err++; $display("FAIL b2b_second_prod: got %h want 0051", p2); end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL b2b_extra_results: got %0d want 0", extra); end
  endtask

  task automatic test_step4();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic        vm [4];
    logic [15:0] vp [4];
    logic        vq [4];
    int lat; logic [15:0] p; logic par;
    logic [7:0] ra, rb; logic rm; logic [15:0] ep;
    va = '{8'hC8, 8'h03, 8'h53, 8'h53};
    vb = '{8'hFF, 8'h07, 8'hCA, 8'hCA};
    vm = '{1'b0, 1'b0, 1'b1, 1'b0};
    vp = '{16'hC738, 16'h0015, 16'h3F7E, 16'h417E};
    vq = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op4(va[i], vb[i], vm[i], lat, p, par);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL s4_lat[%0d]: got %0d want 2", i, lat); end
      n_vec++; if (p !== vp[i]) begin n_err++; $display("FAIL s4_prod[%0d]: got %h want %h", i, p, vp[i]); end
      n_vec++; if (par !== vq[i]) begin n_err++; $display("FAIL s4_par[%0d]: got %b want %b", i, par, vq[i]); end
      hs4();
    end
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      ep = model(ra, rb, rm);
      run_op4(ra, rb, rm, lat, p, par);
      n_vec++; if (p !== ep) begin n_err++; $display("FAIL s4_rand_prod[%0d]: a=%h b=%h m=%b got %h want %h", i, ra, rb, rm, p, ep); end
      n_vec++; if (par !== ^ep) begin n_err++; $display("FAIL s4_rand_par[%0d]: got %b want %b", i, par, ^ep); end
      hs4();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    in_valid8 = 1'b0; in_a8 = 8'h00; in_b8 = 8'h00; in_clmul8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; in_a4 = 8'h00; in_b4 = 8'h00; in_clmul4 = 1'b0; out_ready4 = 1'b0;
    test_reset();
    test_int();
    test_clmul();
    test_hold();
    test_abort();
    test_back_to_back();
    test_step4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
